// File: rtl/layerio_pingpong_ctrl_pkg.sv
// Shared types for the layer I/O ping-pong controller: the size word width
// and the per-bank occupancy state.
package layerio_pingpong_ctrl_pkg;

    localparam int DIGIT = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/layerio_bank_counter.sv
// Size latch plus beat counter for one side (write or read) of the ping-pong:
// holds the layer size, counts accepted beats and flags the final beat.
module layerio_bank_counter
    import layerio_pingpong_ctrl_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DIGIT-1:0] size_i,
    input  logic             sample_i,
    input  logic             beat_i,
    output logic [AW-1:0]    count_o,
    output logic             size_nz_o,
    output logic             size_over_o,
    output logic             last_o
);

    logic [DIGIT-1:0] size_q, size_d;
    logic [AW-1:0]    count_q, count_d;

    assign count_o     = count_q;
    assign size_nz_o   = (size_q != '0);
    assign size_over_o = (size_q > DIGIT'(DEPTH));
    assign last_o      = (DIGIT'(count_q) == size_q - DIGIT'(1));

    // The final beat wraps the count back to zero for the next layer.
    always_comb begin
        size_d  = size_q;
        count_d = count_q;
        if (sample_i) begin
            size_d = size_i;
        end
        if (beat_i) begin
            count_d = last_o ? '0 : count_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            size_q  <= '0;
            count_q <= '0;
        end else begin
            size_q  <= size_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/layerio_pingpong_ctrl.sv
// Two-bank ping-pong controller between a layer writer and a layer reader.
// Handshake: a beat transfers on a cycle where valid and ready are both high.
module layerio_pingpong_ctrl
    import layerio_pingpong_ctrl_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DIGIT-1:0] wr_size,
    input  logic [DIGIT-1:0] rd_size,
    input  logic             islastlayer,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [AW-1:0]    wr_addr,
    output logic             wr_bank,
    input  logic             rd_valid,
    output logic             rd_ready,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_bank,
    output logic             wrote_layer,
    output logic             read_layer,
    output logic [1:0][1:0]  bank_state,
    output logic             size_err
);

    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        wrote_q, read_q, size_err_q;

    bank_state_e wr_state, rd_state;
    logic        wr_fire, rd_fire, wr_sample, rd_sample;
    logic        wr_nz, wr_over, wr_last;
    logic        rd_nz, rd_over, rd_last;

    assign wr_state = state_q[wr_bank_q];
    assign rd_state = state_q[rd_bank_q];

    // Ready depends only on registered state, never on the other side's valid.
    assign wr_ready = (wr_state == BANK_EMPTY || wr_state == BANK_FILLING)
                      && wr_nz && !wr_over && !size_err_q;
    assign rd_ready = (rd_state == BANK_FULL || rd_state == BANK_DRAINING) && rd_nz;

    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_valid && rd_ready;

    // Sizes track the inputs until a layer starts, then freeze for its duration.
    assign wr_sample = (wr_state == BANK_EMPTY) && !wr_fire;
    assign rd_sample = (rd_state != BANK_DRAINING) && !rd_fire;

    layerio_bank_counter #(.DEPTH(DEPTH), .AW(AW)) u_wr_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .size_i      (wr_size),
        .sample_i    (wr_sample),
        .beat_i      (wr_fire),
        .count_o     (wr_addr),
        .size_nz_o   (wr_nz),
        .size_over_o (wr_over),
        .last_o      (wr_last)
    );

    layerio_bank_counter #(.DEPTH(DEPTH), .AW(AW)) u_rd_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .size_i      (rd_size),
        .sample_i    (rd_sample),
        .beat_i      (rd_fire),
        .count_o     (rd_addr),
        .size_nz_o   (rd_nz),
        .size_over_o (rd_over),
        .last_o      (rd_last)
    );

    // Write and read sides can never own the same bank in one cycle, so both
    // updates apply independently.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        for (int b = 0; b < 2; b++) begin
            if (wr_fire && wr_bank_q == 1'(b)) begin
                state_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
            end
            if (rd_fire && rd_bank_q == 1'(b)) begin
                state_d[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
            end
        end
        if (wr_fire && wr_last) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (rd_fire && rd_last) begin
            rd_bank_d = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wrote_q    <= 1'b0;
            read_q     <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wrote_q    <= wr_fire && wr_last && !islastlayer;
            read_q     <= rd_fire && rd_last;
            size_err_q <= size_err_q || wr_over || rd_over;
        end
    end

    assign wr_bank     = wr_bank_q;
    assign rd_bank     = rd_bank_q;
    assign wrote_layer = wrote_q;
    assign read_layer  = read_q;
    assign size_err    = size_err_q;
    assign bank_state  = {state_q[1], state_q[0]};

endmodule
